// File: rtl/cmp_pipe_if.sv
// rtl/cmp_pipe_if.sv - operand/result stream and status bundle for cmp_pipe
interface cmp_pipe_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic             out_result;
    logic             out_eq;
    logic             out_lt;
    logic             out_ltu;
    logic             out_err;
    logic [CNT_W-1:0] mism_cnt;
    logic             cnt_clr;

    // comparator side
    modport slave (
        input  in_valid, in_a, in_b, in_mode, out_ready, cnt_clr,
        output in_ready, out_valid, out_result, out_eq, out_lt, out_ltu, out_err, mism_cnt
    );

    // producer/consumer side
    modport master (
        output in_valid, in_a, in_b, in_mode, out_ready, cnt_clr,
        input  in_ready, out_valid, out_result, out_eq, out_lt, out_ltu, out_err, mism_cnt
    );
endinterface

// File: rtl/cmp_pipe.sv
// rtl/cmp_pipe.sv - pipelined WIDTH-bit comparator with stream handshake and mismatch counter
module cmp_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic      clock,
    input  logic      reset_n,
    cmp_pipe_if.slave bus
);
    // Equality is reduced in NP chunks before the first slice; the final
    // AND of chunk-equal bits happens after the last slice.
    localparam int NP = 4;
    localparam int CH = (WIDTH + NP - 1) / NP;
    localparam int L  = STAGES - 1;

    // Operand capture register in front of the STAGES compute slices, so a
    // beat accepted at edge N is on the outputs after edge N+STAGES.
    logic             cv_q;
    logic [WIDTH-1:0] ca_q;
    logic [WIDTH-1:0] cb_q;
    logic [2:0]       cm_q;

    logic             v_q   [STAGES];
    logic [NP-1:0]    eqp_q [STAGES];
    logic             ltu_q [STAGES];
    logic             sx_q  [STAGES];
    logic [2:0]       md_q  [STAGES];

    logic [NP*CH-1:0] xr_pad;
    logic [NP-1:0]    eqp_d;
    logic             ltu_d;
    logic             sx_d;

    logic             stall;
    logic             adv;
    logic             eq_w;
    logic             lt_w;
    logic             ltu_w;
    logic             err_w;
    logic             res_w;
    logic             xfer_out;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Whole pipe freezes while the head beat is refused; bubbles are kept.
    assign stall = v_q[L] & ~bus.out_ready;
    assign adv   = ~stall;

    // First-slice partials: chunked XOR reduction, borrow of A-B, sign difference.
    always_comb begin
        xr_pad             = '0;
        xr_pad[WIDTH-1:0]  = ca_q ^ cb_q;
        for (int k = 0; k < NP; k++) begin
            eqp_d[k] = ~|xr_pad[k*CH +: CH];
        end
        ltu_d = 1'(({1'b0, ca_q} - {1'b0, cb_q}) >> WIDTH);
        sx_d  = ca_q[WIDTH-1] ^ cb_q[WIDTH-1];
    end

    // Valid bits: shift together on advance, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cv_q <= 1'b0;
            for (int i = 0; i < STAGES; i++) begin
                v_q[i] <= 1'b0;
            end
        end else if (adv) begin
            cv_q   <= bus.in_valid;
            v_q[0] <= cv_q;
            for (int i = 1; i < STAGES; i++) begin
                v_q[i] <= v_q[i-1];
            end
        end
    end

    // Payload moves only with a valid beat, so flags hold across bubbles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ca_q <= '0;
            cb_q <= '0;
            cm_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                eqp_q[i] <= '0;
                ltu_q[i] <= 1'b0;
                sx_q[i]  <= 1'b0;
                md_q[i]  <= '0;
            end
        end else if (adv) begin
            if (bus.in_valid) begin
                ca_q <= bus.in_a;
                cb_q <= bus.in_b;
                cm_q <= bus.in_mode;
            end
            if (cv_q) begin
                eqp_q[0] <= eqp_d;
                ltu_q[0] <= ltu_d;
                sx_q[0]  <= sx_d;
                md_q[0]  <= cm_q;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (v_q[i-1]) begin
                    eqp_q[i] <= eqp_q[i-1];
                    ltu_q[i] <= ltu_q[i-1];
                    sx_q[i]  <= sx_q[i-1];
                    md_q[i]  <= md_q[i-1];
                end
            end
        end
    end

    // Final reduction and mode select on the head slice. Reset payload of
    // all zeros yields eq=lt=ltu=result=err=0.
    always_comb begin
        eq_w  = &eqp_q[L];
        ltu_w = ltu_q[L];
        lt_w  = ltu_w ^ sx_q[L];
        err_w = md_q[L][2] & md_q[L][1];
        res_w = 1'b0;
        case (md_q[L])
            3'd0:    res_w = eq_w;
            3'd1:    res_w = ~eq_w;
            3'd2:    res_w = lt_w;
            3'd3:    res_w = ~lt_w;
            3'd4:    res_w = ltu_w;
            3'd5:    res_w = ~ltu_w;
            default: res_w = 1'b0;
        endcase
    end

    assign xfer_out = v_q[L] & bus.out_ready;

    // Saturating count of delivered unequal beats; clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (xfer_out && !eq_w && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready   = ~stall;
    assign bus.out_valid  = v_q[L];
    assign bus.out_result = res_w;
    assign bus.out_eq     = eq_w;
    assign bus.out_lt     = lt_w;
    assign bus.out_ltu    = ltu_w;
    assign bus.out_err    = err_w;
    assign bus.mism_cnt   = cnt_q;
endmodule

// File: doc/cmp_pipe.md
Name: cmp_pipe

Overview:
- Parametrised, pipelined successor to the team's 32-bit inequality checker.
- Compares two WIDTH-bit operands under a selectable mode: EQ, NE, LT/GE signed, LTU/GEU unsigned.
- Uses a valid/ready stream handshake with full backpressure.
- Keeps a saturating count of unequal results for the ALU status path.

Parameters:
- WIDTH, 32, operand width in bits; legal range 2..64.
- STAGES, 2, pipeline depth and exact input-to-output latency in cycles; legal range 1..4.
- CNT_W, 16, width of the mismatch counter.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_mode  in  3  0=EQ, 1=NE, 2=LT (signed), 3=GE (signed), 4=LTU, 5=GEU, 6/7 reserved.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  1  mode-selected comparison result.
- out_eq  out  1  A==B.
- out_lt  out  1  A<B signed.
- out_ltu  out  1  A<B unsigned.
- out_err  out  1  in_mode was reserved; out_result is 0 in that case.
- mism_cnt  out  CNT_W  saturating count of delivered beats with A!=B.
- cnt_clr  in  1  synchronous clear of mism_cnt.

Behaviour:
- Reset (asynchronous, reset_n=0) clears all pipeline valid bits.
- Reset values: out_valid=0, out_result=0, out_eq=0, out_lt=0, out_ltu=0, out_err=0, mism_cnt=0.
- in_ready is combinational; it is 1 in reset only if STAGES registers are empty, and in practice 1 from the first cycle after reset.
- Transfer rule: a beat transfers on a rising edge where valid&ready are both 1.
- in_a, in_b and in_mode are sampled only on transfer.
- Pipeline:
  - STAGES register slices, each holding a valid bit and partial state.
  - Equality reduces per bit (XOR), then through an OR tree split across stages.
  - Unsigned less-than comes from the borrow of A-B.
  - Signed less-than = MSB-sign XOR correction of the unsigned result.
  - Slice placement is implementation choice; the latency rule is mandatory.
- Latency: a beat accepted at edge N appears on the outputs after edge N+STAGES when no stall occurs.
- Throughput: one beat per cycle with out_ready held at 1.
- Backpressure:
  - stall = out_valid & ~out_ready.
  - During a stall every slice holds; bubbles are not compressed.
  - in_ready = ~stall.
  - Outputs stay stable while out_valid=1 and out_ready=0.
- Empty slices may be overwritten. Bubble collapse is optional; if it is implemented, ordering and per-beat latency ≥ STAGES must still hold, and the bench checks order, not exact timing, under stalls.
- Beat ordering is strictly FIFO.
- mism_cnt:
  - Increments by 1 on each output transfer (out_valid&out_ready) with out_eq=0, in every mode including reserved.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.
- Reserved modes 6 and 7: the beat flows normally with out_err=1, out_result=0, and out_eq/lt/ltu valid.
- Reset mid-operation discards all in-flight beats; no output transfer occurs for them.
- The flags out_eq/lt/ltu/err/result are meaningful only when out_valid=1. They must hold their last value when out_valid=0 (no X).

Test Plan:
- Reset with STAGES=2 → reset_n low with in_valid=1 gives in_ready=1 after release, out_valid=0, mism_cnt=0.
- A=0x0000_0005, B=0xFFFF_FFFF, mode LT → out_result=0 after exactly 2 cycles.
  - Same operands, mode LTU → out_result=1.
  - out_eq=0, out_lt=0, out_ltu=1.
- Back-to-back stream of 8 beats:
  - Beats: EQ on equal operands, NE on operands differing only in bit 31, then GE/GEU/LT/LTU with A=0x8000_0000, B=0x7FFF_FFFF.
  - Required results in order: 1,1,0,1,1,0 plus 2 more EQ beats.
  - No gaps, out_valid contiguous.
- Backpressure: out_ready=0 for 5 cycles mid-stream → outputs frozen, in_ready=0; after release there is no loss or duplication (compare with scoreboard).
- Counter: CNT_W=4, 20 unequal beats → mism_cnt saturates at 15.
  - cnt_clr coincident with an unequal transfer → mism_cnt=0.
  - Mode 7 beat with A≠B → out_err=1, out_result=0, counter increments.
- Mid-stream reset with 2 beats in flight → out_valid=0 immediately (asynchronous); the beats never emerge; a new beat after release arrives with latency 2.
